// File: rtl/jk_ff_access_arbiter.sv
// Round-robin arbiter sharing one external JK flip-flop between NUM_REQ requesters.
// Each granted op drives j/k for one cycle, then checks q against the JK truth table.
module jk_ff_access_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] op,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 rdata,
  output logic                 mismatch,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 ff_j,
  output logic                 ff_k,
  input  logic                 ff_q
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     ptr_reg;
  logic [PTR_W-1:0]     win_reg;
  logic [1:0]           op_reg;
  logic                 q_before_reg;
  logic                 expected_reg;
  logic [ERR_CNT_W-1:0] err_count_reg;

  logic [1:0]           op_arr [NUM_REQ];
  logic                 found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_op
      assign op_arr[gi] = op[2*gi +: 2];
    end
  endgenerate

  // Search upward from the pointer with wrap-around; first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ))
        cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      win_reg       <= '0;
      op_reg        <= 2'b00;
      q_before_reg  <= 1'b0;
      expected_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && found) begin
        win_reg      <= win_idx;
        op_reg       <= op_arr[win_idx];
        q_before_reg <= ff_q;
        if (win_idx == PTR_W'(NUM_REQ-1))
          ptr_reg <= '0;
        else
          ptr_reg <= win_idx + 1'b1;
      end
      if (state_reg == DRIVE) begin
        case (op_reg)
          2'b00:   expected_reg <= q_before_reg;
          2'b01:   expected_reg <= 1'b0;
          2'b10:   expected_reg <= 1'b1;
          default: expected_reg <= ~q_before_reg;
        endcase
      end
      if (state_reg == CHECK && (ff_q != expected_reg) &&
          (err_count_reg != {ERR_CNT_W{1'b1}}))
        err_count_reg <= err_count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = found ? DRIVE : IDLE;
      DRIVE:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are masked during reset so an aborted op never shows a grant or done.
  always_comb begin
    gnt      = '0;
    done     = '0;
    rdata    = 1'b0;
    mismatch = 1'b0;
    busy     = 1'b0;
    ff_j     = 1'b0;
    ff_k     = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (found)
            gnt[win_idx] = 1'b1;
        end
        DRIVE: begin
          busy = 1'b1;
          ff_j = op_reg[1];
          ff_k = op_reg[0];
        end
        CHECK: begin
          busy          = 1'b1;
          done[win_reg] = 1'b1;
          rdata         = ff_q;
          mismatch      = (ff_q != expected_reg);
        end
        default: ;
      endcase
    end
  end

  assign err_count = err_count_reg;

endmodule

// File: tb/tb_jk_ff_access_arbiter.sv
// Directed bench for jk_ff_access_arbiter with a local JK flip-flop model on the flop port.
module tb_jk_ff_access_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] op;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic                 rdata;
  logic                 mismatch;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 ff_j;
  logic                 ff_k;
  logic                 ff_q;

  logic q_model;
  logic force_q0;

  int n_cmp = 0;
  int n_err = 0;

  jk_ff_access_arbiter #(.NUM_REQ(NUM_REQ), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .gnt(gnt), .done(done),
    .rdata(rdata), .mismatch(mismatch), .busy(busy), .err_count(err_count),
    .ff_j(ff_j), .ff_k(ff_k), .ff_q(ff_q)
  );

  always #5 clk = ~clk;

  // External JK flop, reset by the same net.
  always_ff @(posedge clk) begin
    if (reset) q_model <= 1'b0;
    else begin
      case ({ff_j, ff_k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

  assign ff_q = force_q0 ? 1'b0 : q_model;

  localparam logic [1:0] HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TGL = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full op by a single requester starting in IDLE.
  task automatic do_op(input int r, input logic [1:0] o, input logic exp_q, input string tag);
    logic [NUM_REQ-1:0] onehot;
    onehot = '0;
    onehot[r] = 1'b1;
    req = onehot;
    op[2*r +: 2] = o;
    #1;
    chk({tag, " gnt"}, 32'(gnt), 32'(onehot));
    cyc();
    req = '0;
    #1;
    chk({tag, " drive jk"}, 32'({ff_j, ff_k}), 32'(o));
    chk({tag, " drive busy"}, 32'(busy), 32'd1);
    cyc();
    chk({tag, " done"}, 32'(done), 32'(onehot));
    chk({tag, " rdata"}, 32'(rdata), 32'(exp_q));
    chk({tag, " mismatch"}, 32'(mismatch), 32'd0);
    chk({tag, " check gnt"}, 32'(gnt), 32'd0);
    $display("op r=%0d op=%b rdata=%0d mismatch=%0d", r, o, rdata, mismatch);
    cyc();
  endtask

  initial begin
    logic [1:0] exp_w [4];
    logic       exp_r [4];
    force_q0 = 1'b0;
    reset = 1'b1;
    req   = '0;
    op    = '0;
    cyc();
    cyc();
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset jk", 32'({ff_j, ff_k}), 32'd0);
    chk("reset err", 32'(err_count), 32'd0);
    reset = 1'b0;
    #1;

    do_op(0, SET, 1'b1, "single set");

    do_op(1, SET,  1'b1, "walk set");
    do_op(1, HOLD, 1'b1, "walk hold");
    do_op(1, RST,  1'b0, "walk reset");
    do_op(1, TGL,  1'b1, "walk tgl1");
    do_op(1, TGL,  1'b0, "walk tgl2");
    chk("walk err", 32'(err_count), 32'd0);

    // Round robin: both requesters held, both toggle, q starts at 0.
    exp_w = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_r = '{1'b1, 1'b0, 1'b1, 1'b0};
    req = 2'b11;
    op  = {TGL, TGL};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr gnt", 32'(gnt), 32'(exp_w[i]));
      cyc();
      cyc();
      chk("rr done", 32'(done), 32'(exp_w[i]));
      chk("rr rdata", 32'(rdata), 32'(exp_r[i]));
      $display("rr op %0d gnt=%b done=%b rdata=%0d", i, exp_w[i], done, rdata);
      if (i == 3) req = '0;
      cyc();
    end

    // Fault injection: q forced low during CHECK of each SET.
    op = {SET, SET};
    for (int i = 0; i < 300; i++) begin
      req = 2'b01;
      cyc();
      req = '0;
      cyc();
      force_q0 = 1'b1;
      #1;
      if (i == 0) begin
        chk("fault done", 32'(done), 32'd1);
        chk("fault rdata", 32'(rdata), 32'd0);
        chk("fault mismatch", 32'(mismatch), 32'd1);
      end
      cyc();
      force_q0 = 1'b0;
      if (i == 0) chk("fault err1", 32'(err_count), 32'd1);
    end
    $display("fault x300 err_count=%0d", err_count);
    chk("fault saturate", 32'(err_count), 32'd255);

    // Reset during DRIVE aborts the op and restores pointer to 0.
    req = 2'b01;
    op  = {SET, RST};
    cyc();
    req   = '0;
    reset = 1'b1;
    #1;
    chk("midrst drive jk", 32'({ff_j, ff_k}), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst jk", 32'({ff_j, ff_k}), 32'd0);
    chk("midrst err", 32'(err_count), 32'd0);
    cyc();
    chk("midrst idle done", 32'(done), 32'd0);
    req = 2'b11;
    op  = {SET, SET};
    #1;
    chk("midrst ptr0 gnt", 32'(gnt), 32'd1);
    cyc();
    req = '0;
    cyc();
    chk("midrst op rdata", 32'(rdata), 32'd1);
    $display("post-reset op r=0 rdata=%0d", rdata);
    cyc();
    do_op(1, RST, 1'b0, "midrst req1");

    // Late request during CHECK; op changed after grant must be ignored.
    req = 2'b10;
    op  = {TGL, 2'b00};
    #1;
    chk("late gnt1", 32'(gnt), 32'd2);
    cyc();
    req = '0;
    cyc();
    req = 2'b01;
    op[1:0] = SET;
    #1;
    chk("late done1", 32'(done), 32'd2);
    chk("late rdata1", 32'(rdata), 32'd1);
    chk("late no gnt", 32'(gnt), 32'd0);
    cyc();
    chk("late gnt0", 32'(gnt), 32'd1);
    cyc();
    req = '0;
    op[1:0] = RST;
    #1;
    chk("late jk", 32'({ff_j, ff_k}), 32'(SET));
    cyc();
    chk("late done0", 32'(done), 32'd1);
    chk("late rdata0", 32'(rdata), 32'd1);
    chk("late mismatch", 32'(mismatch), 32'd0);
    $display("late op r=0 applied op=SET rdata=%0d", rdata);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
